instr_trace_fifo: RTL and testbench

Captures one trace record (sequence number, PC, instruction word) for every instruction fetch the multicycle MIPS CPU performs, and buffers the records in a small FIFO. The FIFO drains through a valid/ready port to the bench-side consumer that writes the per-instruction log file. The block sits directly downstream of the CPU's fetch path: it taps the PC register output, the memory instruction word and the IR-load strobe. It never alters CPU behaviour unless the stall feature is compiled in.

---
 rtl/cpu_trace_pkg.sv | 14 +
 rtl/instr_trace_fifo_if.sv | 18 +
 rtl/trace_fifo_mem.sv | 32 +++
 rtl/instr_trace_fifo.sv | 118 +++++++++++
 tb/tb_instr_trace_fifo.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared trace types and default sizing for the instruction trace FIFO.
package cpu_trace_pkg;

    localparam int TRACE_DEPTH = 16;
    localparam int TRACE_SEQ_W = 16;

    // One captured fetch: sequence number, fetch PC and the fetched word.
    typedef struct packed {
        logic [TRACE_SEQ_W-1:0] seq;
        logic [31:0]            pc;
        logic [31:0]            instr;
    } trace_entry_t;

endpackage

// File: rtl/instr_trace_fifo_if.sv
// Drain-side valid/ready port of the trace FIFO.
// The master drives the head record, the slave returns out_ready.
interface instr_trace_fifo_if
    import cpu_trace_pkg::*;
#(
    parameter int SEQ_W = TRACE_SEQ_W
);
    logic             out_valid;
    logic             out_ready;
    logic [SEQ_W-1:0] out_seq;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;

    modport master (output out_valid, output out_seq, output out_pc, output out_instr,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_seq, input  out_pc, input  out_instr,
                    output out_ready);
endinterface

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one write port, one asynchronous read port.
// Storage is intentionally not reset; validity is tracked by the FIFO control.
module trace_fifo_mem
    import cpu_trace_pkg::*;
#(
    parameter int  DEPTH   = TRACE_DEPTH,
    parameter type entry_t = trace_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);
    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    // Next storage contents: only the addressed slot changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // Storage update, no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_trace_fifo.sv
// Instruction fetch trace capture with a first-word-fall-through FIFO.
// Optional build macro: TRACE_STALL_EN adds a stall output that asks the
// CPU to hold its fetch while the FIFO is full and not being drained.
module instr_trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int  DEPTH = TRACE_DEPTH,
    parameter int  SEQ_W = TRACE_SEQ_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cap_en,
    input  logic               ir_load,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        instr_in,
    input  logic               flush,
    instr_trace_fifo_if.master tr,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [SEQ_W-1:0]   drop_count
`ifdef TRACE_STALL_EN
    ,
    output logic               stall
`endif
);
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [31:0]      pc;
        logic [31:0]      instr;
    } entry_t;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] drop_q, drop_d;

    logic   push_req, push_ok, drop, pop;
    entry_t wr_entry, rd_entry;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = tr.out_valid & tr.out_ready;
    assign push_req = ir_load & cap_en & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign wr_entry = '{seq: seq_q, pc: pc_in, instr: instr_in};

    trace_fifo_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Next-state for pointers, occupancy, sequence and drop counters; flush wins.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        drop_d   = drop_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            seq_d    = '0;
            drop_d   = '0;
        end else begin
            // Dropped fetches still consume a sequence number so the log shows the gap.
            if (push_req) seq_d = seq_q + SEQ_W'(1);
            if (push_ok)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop);
            if (drop && (drop_q != '1)) drop_d = drop_q + SEQ_W'(1);
        end
    end

    // Control state registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end

    // Head fields are forced to zero while nothing is valid, so reset outputs are clean.
    assign tr.out_valid = ~empty;
    assign tr.out_seq   = tr.out_valid ? rd_entry.seq   : '0;
    assign tr.out_pc    = tr.out_valid ? rd_entry.pc    : '0;
    assign tr.out_instr = tr.out_valid ? rd_entry.instr : '0;

    assign count      = count_q;
    assign drop_count = drop_q;

`ifdef TRACE_STALL_EN
    assign stall = full & ~pop;
`endif
endmodule

// File: tb/tb_instr_trace_fifo.sv
// Scoreboard bench for instr_trace_fifo (default build and TRACE_STALL_EN build).
module tb_instr_trace_fifo;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cap_en;
    logic        ir_load;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_count;
`ifdef TRACE_STALL_EN
    logic        stall;
`endif

    instr_trace_fifo_if #(.SEQ_W(SEQ_W)) tr ();

    instr_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (cap_en),
        .ir_load    (ir_load),
        .pc_in      (pc_in),
        .instr_in   (instr_in),
        .flush      (flush),
        .tr         (tr),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .drop_count (drop_count)
`ifdef TRACE_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    int          m_count = 0;
    logic [15:0] m_seq   = '0;
    logic [15:0] m_drop  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step(input logic ir, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic ce);
        logic pop;
        logic full_m;
        exp_t e;
        ir_load = ir; pc_in = pc; instr_in = ins;
        tr.out_ready = rdy; flush = fl; cap_en = ce;
        #1;
        full_m = (m_count == DEPTH);
        pop    = (m_count != 0) && rdy;
        chk("count", count, m_count);
        chk("empty", empty, m_count == 0);
        chk("full",  full,  full_m);
        chk("valid", tr.out_valid, m_count != 0);
        chk("drops", drop_count, m_drop);
`ifdef TRACE_STALL_EN
        chk("stall", stall, full_m && !pop);
        // The CPU holds its fetch while stalled.
        if (full_m && !pop) begin
            ir = 1'b0;
            ir_load = 1'b0;
            #1;
        end
`endif
        if (pop) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("head_seq",   tr.out_seq,   e.seq);
                chk("head_pc",    tr.out_pc,    e.pc);
                chk("head_instr", tr.out_instr, e.instr);
            end
        end
        if (fl) begin
            sb_q.delete();
            m_count = 0; m_seq = '0; m_drop = '0;
        end else begin
            if (pop) m_count--;
            if (ir && ce) begin
                if (!full_m || pop) begin
                    sb_q.push_back('{seq: m_seq, pc: pc, instr: ins});
                    m_count++;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop++;
                end
                m_seq++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic rdy);
        step(1'b1, pc, pc ^ 32'hA5A5_0000, rdy, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        sb_q.delete();
        m_count = 0; m_seq = '0; m_drop = '0;
        chk("rst_count", count, 0);
        chk("rst_valid", tr.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; cap_en = 1'b1; ir_load = 1'b0; pc_in = '0; instr_in = '0;
        flush = 1'b0; tr.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", tr.out_valid, 0);
        chk("rst_seq",   tr.out_seq,   0);
        chk("rst_pc",    tr.out_pc,    0);
        chk("rst_instr", tr.out_instr, 0);
        chk("rst_count", count, 0);
        chk("rst_full",  full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_drops", drop_count, 0);
`ifdef TRACE_STALL_EN
        chk("rst_stall", stall, 0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Three fetches, then drain in order.
        push(32'h0, 1'b0);
        push(32'h4, 1'b0);
        push(32'h8, 1'b0);
        drain();

        // Overflow with the consumer stalled: 20 fetches into 16 slots.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) push(32'h100 + 32'(4 * i), 1'b0);
        idle(1'b0);
`ifndef TRACE_STALL_EN
        chk("drop4", drop_count, 4);
`endif
        chk("full16", full, 1);
        drain();
        push(32'h200, 1'b0);
        drain();

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) push(32'h300 + 32'(4 * i), 1'b0);
        push(32'h3FC, 1'b1);
        idle(1'b0);
        chk("full_pp_count", count, DEPTH);
        drain();

        // Flush together with a fetch while holding five entries.
        for (int i = 0; i < 5; i++) push(32'h400 + 32'(4 * i), 1'b0);
        step(1'b1, 32'h4FC, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        chk("flush_valid", tr.out_valid, 0);
        push(32'h500, 1'b0);
        chk("flush_seq0", tr.out_seq, 0);
        drain();

        // Reset mid-stream, then fetches with capture disabled.
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 1'b0);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h700 + 32'(4 * i), 32'h1, 1'b1, 1'b0, 1'b0);
        push(32'h800, 1'b0);
        chk("capen_seq0", tr.out_seq, 0);
        drain();

        // Random traffic mix.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0 ? (i % 64 < 40 ? 0 : 1) : 1),
                 1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 7) != 0));
        end
        drain();
        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
